// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_pkg
// Description : Shared types and constants for the MEM-stage store buffer.
//               Provides the default widths, the buffer entry view, the
//               pointer-width helper and the memory-port arbitration cases.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

  localparam int SB_ADDR_BITS = 64;
  localparam int SB_DATA_BITS = 64;
  localparam int SB_DEPTH     = 4;

  // Pointer width includes one extra wrap bit above the slot index.
  localparam int SB_PTR_W = $clog2(SB_DEPTH) + 1;

  // Packed view of one buffer entry at the default widths.
  typedef struct packed {
    logic                    valid;
    logic [SB_ADDR_BITS-1:0] addr;
    logic [SB_DATA_BITS-1:0] data;
  } sb_entry_t;

  // Which rule owns the single memory port in a given cycle.
  typedef enum logic [2:0] {
    ARB_FULL_DRAIN = 3'd0,
    ARB_LOAD_HIT   = 3'd1,
    ARB_LOAD_MISS  = 3'd2,
    ARB_DRAIN      = 3'd3,
    ARB_IDLE       = 3'd4
  } sb_arb_e;

  function automatic int sb_ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_sb_fwd_match.sv
`default_nettype none
// ============================================================================
// Module      : mem_sb_fwd_match
// Description : Compares every buffer entry against a load address and
//               returns the youngest valid matching entry.
// Ports       : valid_i     - per-slot valid bits
//               addr_i      - per-slot addresses, slot k at [k*ADDR_BITS +:]
//               youngest_i  - slot index of the most recently enqueued entry
//               load_addr_i - address being loaded
//               hit_o       - at least one valid entry matches
//               idx_o       - slot of the youngest matching entry
// Revision    : 1.0 - initial release
// ============================================================================
module mem_sb_fwd_match
  import mem_stage_pkg::*;
#(
  parameter int DEPTH     = SB_DEPTH,
  parameter int ADDR_BITS = SB_ADDR_BITS,
  parameter int IDX_W     = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]           valid_i,
  input  logic [DEPTH*ADDR_BITS-1:0] addr_i,
  input  logic [IDX_W-1:0]           youngest_i,
  input  logic [ADDR_BITS-1:0]       load_addr_i,
  output logic                       hit_o,
  output logic [IDX_W-1:0]           idx_o
);

  logic [DEPTH-1:0] match;
  logic [IDX_W-1:0] slot;

  for (genvar k = 0; k < DEPTH; k++) begin : g_cmp
    assign match[k] = valid_i[k] && (addr_i[k*ADDR_BITS +: ADDR_BITS] == load_addr_i);
  end

  // Walk from oldest to youngest so the youngest match is written last and
  // wins. Slot arithmetic wraps naturally because DEPTH is a power of two.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    slot  = '0;
    for (int age = DEPTH - 1; age >= 0; age--) begin
      slot = youngest_i - IDX_W'(age);
      if (match[slot]) begin
        hit_o = 1'b1;
        idx_o = slot;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : mem_store_buffer
// Description : Write buffer between the EX/MEM register and a single-port
//               data memory. Queues retiring stores, drains them when the
//               port is free and forwards buffered data to younger loads.
// Config      : STORE_COALESCE_EN - when defined, a store to the address of
//               the youngest valid entry overwrites that entry in place.
// Ports       : clk, rst (async, active-high)
//               storeValid/storeAddress/storeData in, storeReady out
//               loadValid/loadAddress in, loadStall out
//               fwdHit/fwdData out (registered, one cycle after the load)
//               memAddress/memWriteData/memWrite/memRead out to memory
//               bufEmpty out - no stores pending
// Revision    : 1.0 - initial release
// ============================================================================
module mem_store_buffer
  import mem_stage_pkg::*;
#(
  parameter int DATA_BITS = SB_DATA_BITS,
  parameter int ADDR_BITS = SB_ADDR_BITS,
  parameter int DEPTH     = SB_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 storeValid,
  input  logic [ADDR_BITS-1:0] storeAddress,
  input  logic [DATA_BITS-1:0] storeData,
  output logic                 storeReady,
  input  logic                 loadValid,
  input  logic [ADDR_BITS-1:0] loadAddress,
  output logic                 loadStall,
  output logic                 fwdHit,
  output logic [DATA_BITS-1:0] fwdData,
  output logic [ADDR_BITS-1:0] memAddress,
  output logic [DATA_BITS-1:0] memWriteData,
  output logic                 memWrite,
  output logic                 memRead,
  output logic                 bufEmpty
);

  localparam int PTR_W = sb_ptr_width(DEPTH);
  localparam int IDX_W = PTR_W - 1;

  logic [PTR_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]     tail_q, tail_d;
  logic [DEPTH-1:0]     valid_q;
  logic [ADDR_BITS-1:0] addr_q [DEPTH];
  logic [DATA_BITS-1:0] data_q [DEPTH];
  logic                 fwdHit_q, fwdHit_d;
  logic [DATA_BITS-1:0] fwdData_q, fwdData_d;

  logic [IDX_W-1:0]     head_idx, tail_idx, young_idx, hit_idx;
  logic                 full, empty, hit, coalesce, enq;
  logic [DEPTH*ADDR_BITS-1:0] addr_flat;
  sb_arb_e              arb_case;

  assign head_idx  = head_q[IDX_W-1:0];
  assign tail_idx  = tail_q[IDX_W-1:0];
  assign young_idx = tail_idx - IDX_W'(1);

  assign empty = (head_q == tail_q);
  assign full  = (head_idx == tail_idx) && (head_q[PTR_W-1] != tail_q[PTR_W-1]);

  for (genvar k = 0; k < DEPTH; k++) begin : g_flat
    assign addr_flat[k*ADDR_BITS +: ADDR_BITS] = addr_q[k];
  end

  mem_sb_fwd_match #(
    .DEPTH     (DEPTH),
    .ADDR_BITS (ADDR_BITS),
    .IDX_W     (IDX_W)
  ) u_fwd_match (
    .valid_i     (valid_q),
    .addr_i      (addr_flat),
    .youngest_i  (young_idx),
    .load_addr_i (loadAddress),
    .hit_o       (hit),
    .idx_o       (hit_idx)
  );

  // Port arbitration. Reset forces the idle case so every output shows its
  // reset value the moment rst rises, independent of the inputs.
  always_comb begin
    arb_case = ARB_IDLE;
    if (rst)                   arb_case = ARB_IDLE;
    else if (full)             arb_case = ARB_FULL_DRAIN;
    else if (loadValid && hit) arb_case = ARB_LOAD_HIT;
    else if (loadValid)        arb_case = ARB_LOAD_MISS;
    else if (!empty)           arb_case = ARB_DRAIN;
  end

  always_comb begin
    memWrite     = 1'b0;
    memRead      = 1'b0;
    memAddress   = '0;
    memWriteData = '0;
    loadStall    = 1'b0;
    fwdHit_d     = 1'b0;
    fwdData_d    = fwdData_q;
    case (arb_case)
      ARB_FULL_DRAIN: begin
        memWrite     = 1'b1;
        memAddress   = addr_q[head_idx];
        memWriteData = data_q[head_idx];
        loadStall    = loadValid;
      end
      ARB_LOAD_HIT: begin
        // Load is served from the buffer, so the port is free to drain.
        memWrite  = !empty;
        fwdHit_d  = 1'b1;
        fwdData_d = data_q[hit_idx];
        if (!empty) begin
          memAddress   = addr_q[head_idx];
          memWriteData = data_q[head_idx];
        end
      end
      ARB_LOAD_MISS: begin
        memRead    = 1'b1;
        memAddress = loadAddress;
      end
      ARB_DRAIN: begin
        memWrite     = 1'b1;
        memAddress   = addr_q[head_idx];
        memWriteData = data_q[head_idx];
      end
      default: ;
    endcase
  end

`ifdef STORE_COALESCE_EN
  // Merge into the youngest entry unless it is the head leaving this cycle.
  assign coalesce = storeValid && !empty && valid_q[young_idx] &&
                    (addr_q[young_idx] == storeAddress) &&
                    !(memWrite && (young_idx == head_idx));
`else
  assign coalesce = 1'b0;
`endif

  assign storeReady = !full || coalesce;
  assign enq        = storeValid && storeReady && !coalesce;
  assign bufEmpty   = empty;
  assign fwdHit     = fwdHit_q;
  assign fwdData    = fwdData_q;

  assign head_d = memWrite ? head_q + PTR_W'(1) : head_q;
  assign tail_d = enq      ? tail_q + PTR_W'(1) : tail_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      valid_q   <= '0;
      fwdHit_q  <= 1'b0;
      fwdData_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        addr_q[k] <= '0;
        data_q[k] <= '0;
      end
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      fwdHit_q  <= fwdHit_d;
      fwdData_q <= fwdData_d;
      // Dequeue and enqueue never target the same slot: that would need the
      // buffer to be both empty (no drain) and full (no enqueue).
      if (memWrite) valid_q[head_idx] <= 1'b0;
      if (coalesce) data_q[young_idx] <= storeData;
      if (enq) begin
        valid_q[tail_idx] <= 1'b1;
        addr_q[tail_idx]  <= storeAddress;
        data_q[tail_idx]  <= storeData;
      end
    end
  end

endmodule
`default_nettype wire
